// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : two-port arbiter feeding one shared combinational ALU.
// Build option: ALU_ARB_FIXED_PRIO_EN (port 0 always wins contention).
// Revision    : 1.0
// ============================================================================
module alu_arbiter (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][3:0]  req_op_i,
  input  logic [1:0][31:0] req_a_i,
  input  logic [1:0][31:0] req_b_i,
  output logic [3:0]       alu_op_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  input  logic [31:0]      alu_out_i,
  output logic [1:0]       rsp_valid_o,
  output logic [1:0][31:0] rsp_data_o,
  input  logic [1:0]       rsp_ready_i
);

  logic             ex_valid_q, ex_valid_d;
  logic             ex_port_q, ex_port_d;
  logic [3:0]       ex_op_q, ex_op_d;
  logic [31:0]      ex_a_q, ex_a_d;
  logic [31:0]      ex_b_q, ex_b_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0][31:0] rsp_data_q, rsp_data_d;

  logic [1:0] ex_dst;
  logic [1:0] eligible;
  logic [1:0] grant;

  // A port is blocked while its op sits in EX or its response slot is full and not draining.
  assign ex_dst   = {ex_valid_q & ex_port_q, ex_valid_q & ~ex_port_q};
  assign eligible = req_valid_i & ~ex_dst & ~(rsp_valid_q & ~rsp_ready_i);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (eligible[0]) begin
      grant = 2'b01;
    end else if (eligible[1]) begin
      grant = 2'b10;
    end
  end
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant        = eligible;
    last_grant_d = last_grant_q;
    if (eligible == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
    if (grant[1]) begin
      last_grant_d = 1'b1;
    end else if (grant[0]) begin
      last_grant_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign req_ready_o = grant & {2{rst_n}};

  always_comb begin
    ex_valid_d = |grant;
    ex_port_d  = ex_port_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (grant[0]) begin
      ex_port_d = 1'b0;
      ex_op_d   = req_op_i[0];
      ex_a_d    = req_a_i[0];
      ex_b_d    = req_b_i[0];
    end else if (grant[1]) begin
      ex_port_d = 1'b1;
      ex_op_d   = req_op_i[1];
      ex_a_d    = req_a_i[1];
      ex_b_d    = req_b_i[1];
    end
  end

  // A result written at the same edge as a pop takes precedence over the clear.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid_q[i] & rsp_ready_i[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      if (ex_dst[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = alu_out_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_port_q   <= 1'b0;
      ex_op_q     <= 4'd0;
      ex_a_q      <= 32'd0;
      ex_b_q      <= 32'd0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_port_q   <= ex_port_d;
      ex_op_q     <= ex_op_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign alu_op_o    = ex_op_q;
  assign alu_a_o     = ex_a_q;
  assign alu_b_o     = ex_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed scoreboard bench for alu_arbiter with a local ALU.
// Revision       : 1.0
// ============================================================================
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_PACK = 4'd12;
  localparam logic [3:0] OP_NOT  = 4'd15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [1:0][3:0]  req_op_i;
  logic [1:0][31:0] req_a_i, req_b_i, rsp_data_o;
  logic [3:0]       alu_op_o;
  logic [31:0]      alu_a_o, alu_b_o, alu_out_i;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .alu_op_o    (alu_op_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_out_i   (alu_out_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_ready_i (rsp_ready_i)
  );

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return {31'd0, $signed(a) < $signed(b)};
      4'd9:    return {31'd0, a < b};
      4'd12:   return {a[15:0], b[15:0]};
      4'd15:   return ~a;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_out_i = alu_model(alu_op_o, alu_a_o, alu_b_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op_i[p] = op;
    req_a_i[p]  = a;
    req_b_i[p]  = b;
  endtask

  // Holds the request until granted, then records the expected result for that port.
  task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    logic got;
    got = 1'b0;
    set_req(p, op, a, b);
    req_valid_i[p] = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      #1;
      if (req_ready_o[p]) begin
        got = 1'b1;
        if (p == 0) exp_q0.push_back(exp);
        else        exp_q1.push_back(exp);
      end
      tick();
    end
    req_valid_i[p] = 1'b0;
    chk("issue_granted", {31'd0, got}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rsp_valid_o[0] && rsp_ready_i[0]) begin
        if (exp_q0.size() == 0) chk("rsp0_unexpected", {31'd0, rsp_valid_o[0]}, 32'd0);
        else                    chk("rsp0_data", rsp_data_o[0], exp_q0.pop_front());
      end
      if (rsp_valid_o[1] && rsp_ready_i[1]) begin
        if (exp_q1.size() == 0) chk("rsp1_unexpected", {31'd0, rsp_valid_o[1]}, 32'd0);
        else                    chk("rsp1_data", rsp_data_o[1], exp_q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    req_valid_i = 2'b00;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 2'b11;
    repeat (2) tick();
    req_valid_i = 2'b11;
    #1;
    chk("rst_ready", {30'd0, req_ready_o}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("rst_alu_a", alu_a_o, 32'd0);
    chk("rst_rsp_data0", rsp_data_o[0], 32'd0);
    req_valid_i = 2'b00;
    tick();
    rst_n = 1'b1;

    // contention: both ports requesting every cycle
    set_req(0, OP_ADD, 32'd1, 32'd1);
    set_req(1, OP_ADD, 32'd2, 32'd2);
    req_valid_i = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("contend_grant", {30'd0, req_ready_o}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k % 2 == 0) exp_q0.push_back(32'd2);
      else            exp_q1.push_back(32'd4);
      tick();
    end
    req_valid_i = 2'b00;
    repeat (3) tick();

    // single op latency
    set_req(0, OP_ADD, 32'd5, 32'd7);
    req_valid_i = 2'b01;
    #1;
    chk("single_ready", {30'd0, req_ready_o}, 32'd1);
    exp_q0.push_back(32'd12);
    tick();
    req_valid_i = 2'b00;
    chk("single_lat1_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("single_alu_op", {28'd0, alu_op_o}, 32'd0);
    chk("single_alu_a", alu_a_o, 32'd5);
    chk("single_alu_b", alu_b_o, 32'd7);
    tick();
    chk("single_lat2_valid", {30'd0, rsp_valid_o}, 32'd1);
    chk("single_data", rsp_data_o[0], 32'd12);
    chk("alu_hold_a", alu_a_o, 32'd5);
    tick();
    chk("single_popped", {30'd0, rsp_valid_o}, 32'd0);

    // backpressure on port 1
    rsp_ready_i = 2'b01;
    issue(1, OP_SUB, 32'd3, 32'd10, 32'hFFFF_FFF9);
    tick();
    set_req(1, OP_ADD, 32'd1, 32'd2);
    set_req(0, OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    req_valid_i = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_grant", {30'd0, req_ready_o}, (k == 0) ? 32'd1 : 32'd0);
      chk("bp_valid1", {31'd0, rsp_valid_o[1]}, 32'd1);
      chk("bp_hold1", rsp_data_o[1], 32'hFFFF_FFF9);
      if (k == 0) exp_q0.push_back(32'h0FF0_0FF0);
      tick();
      if (k == 0) req_valid_i[0] = 1'b0;
    end
    rsp_ready_i[1] = 1'b1;
    #1;
    chk("bp_release", {30'd0, req_ready_o}, 32'd2);
    exp_q1.push_back(32'd3);
    tick();
    req_valid_i = 2'b00;
    repeat (3) tick();

    // back-to-back port 0 with responses consumed immediately
    rsp_ready_i = 2'b11;
    set_req(0, OP_OR, 32'h00FF_0000, 32'h0000_00FF);
    req_valid_i = 2'b01;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("b2b_grant", {30'd0, req_ready_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k == 0) exp_q0.push_back(32'h00FF_00FF);
      if (k == 2) exp_q0.push_back(32'h0000_0010);
      if (k == 4) exp_q0.push_back(32'hF800_0000);
      tick();
      if (k == 0) set_req(0, OP_SLL, 32'd1, 32'd4);
      if (k == 2) set_req(0, OP_SRA, 32'h8000_0000, 32'd4);
    end
    req_valid_i = 2'b00;
    repeat (3) tick();

    // compare / pass-through op codes
    issue(1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue(1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue(1, OP_PACK, 32'h1234_ABCD, 32'h5678_EF01, 32'hABCD_EF01);
    issue(0, OP_NOT, 32'd0, 32'd0, 32'hFFFF_FFFF);
    repeat (4) tick();

    // reset with work in flight; port 0 was granted last before reset
    rsp_ready_i = 2'b00;
    issue(1, OP_ADD, 32'd2, 32'd2, 32'd4);
    set_req(0, OP_ADD, 32'd1, 32'd1);
    req_valid_i = 2'b11;
    #1;
    chk("mid_grant0", {30'd0, req_ready_o}, 32'd1);
    tick();
    chk("mid_pre_valid", {30'd0, rsp_valid_o}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_clear", {30'd0, rsp_valid_o}, 32'd0);
    chk("mid_ready_clear", {30'd0, req_ready_o}, 32'd0);
    chk("mid_alu_a_clear", alu_a_o, 32'd0);
    chk("mid_data_clear", rsp_data_o[1], 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    req_valid_i = 2'b00;
    repeat (2) tick();
    rsp_ready_i = 2'b11;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_rst_quiet", {30'd0, rsp_valid_o}, 32'd0);
      tick();
    end

    // first contention after reset goes to port 0
    set_req(0, OP_ADD, 32'd10, 32'd20);
    set_req(1, OP_SUB, 32'd20, 32'd10);
    req_valid_i = 2'b11;
    #1;
    chk("post_rst_prio", {30'd0, req_ready_o}, 32'd1);
    exp_q0.push_back(32'd30);
    tick();
    chk("post_rst_second", {30'd0, req_ready_o}, 32'd2);
    exp_q1.push_back(32'd10);
    tick();
    req_valid_i = 2'b00;
    repeat (4) tick();

    chk("sb_drain", exp_q0.size() + exp_q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
